membus_ram_responder: RTL and testbench

// - Device-side membus responder: a slave memory sitting behind one device master port
//   of the MMIO controller (or directly on a core port in unit benches).
// - Accepts one request at a time and applies byte-masked writes.
// - Returns a single-cycle rvalid after a fixed LATENCY, for reads AND writes.
// - Implements the ready/rvalid contract the MMIO controller's device masters rely on.

---
 rtl/eei_pkg.sv | 11 +
 rtl/membus_if.sv | 29 ++
 rtl/membus_ram_array.sv | 27 ++
 rtl/membus_ram_responder.sv | 152 +++++++++++++++
 tb/tb_membus_ram_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/eei_pkg.sv
// Shared execution-environment types.
// Membus widths and the address/byte-mask typedefs.
package eei;

    localparam int MEM_DATA_WIDTH = 64;
    localparam int MEM_ADDR_WIDTH = 64;

    typedef logic [MEM_ADDR_WIDTH-1:0]   Addr;
    typedef logic [MEM_DATA_WIDTH/8-1:0] WMask;

endpackage

// File: rtl/membus_if.sv
// Membus request/response interface.
// Master drives the request, slave returns ready/rvalid/rdata.
interface membus_if
    import eei::*;
#(
    parameter int DATA_WIDTH = MEM_DATA_WIDTH,
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

    logic                    valid;
    logic                    ready;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );

endinterface

// File: rtl/membus_ram_array.sv
// Word-organised storage with a byte-enable write port
// and a registered read port sharing one index.
module membus_ram_array #(
    parameter int    DATA_WIDTH  = 64,
    parameter int    INDEX_WIDTH = 12,
    parameter string INIT_FILE   = ""
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [INDEX_WIDTH-1:0]  idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**INDEX_WIDTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < DATA_WIDTH / 8; k++) begin
            if (we && be[k]) begin
                mem[idx][k*8 +: 8] <= wdata[k*8 +: 8];
            end
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/membus_ram_responder.sv
// Membus slave memory: one request in flight, fixed response latency,
// byte-masked writes and an access fault outside its window.
module membus_ram_responder
    import eei::*;
#(
    parameter int                    DATA_WIDTH  = MEM_DATA_WIDTH,
    parameter int                    ADDR_WIDTH  = MEM_ADDR_WIDTH,
    parameter int                    INDEX_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    LATENCY     = 1,
    parameter string                 INIT_FILE   = ""
) (
    input  logic     clk,
    input  logic     rst,
    membus_if.slave  bus,
    output logic     access_fault
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] SPAN =
        ADDR_WIDTH'(longint'(BYTES) << INDEX_WIDTH);
    localparam logic [3:0] CNT_INIT =
        4'((LATENCY > 1) ? LATENCY - 2 : 0);
    localparam bit FROM_BUS = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                 state_q;
    logic [3:0]             cnt_q;
    logic                   ready_q;
    logic                   rvalid_q;
    logic                   fault_q;
    logic                   rzero_q;
    logic [INDEX_WIDTH-1:0] rd_idx_q;

    logic [INDEX_WIDTH-1:0] idx_q;
    logic                   wen_q;
    logic                   flt_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [BYTES-1:0]       wmask_q;

    logic [ADDR_WIDTH-1:0]  off;
    logic [INDEX_WIDTH-1:0] in_idx;
    logic                   in_flt;
    logic                   accept;
    logic                   commit;
    logic [INDEX_WIDTH-1:0] c_idx;
    logic                   c_wen;
    logic                   c_flt;
    logic [DATA_WIDTH-1:0]  c_wdata;
    logic [BYTES-1:0]       c_wmask;
    logic                   mem_we;
    logic [INDEX_WIDTH-1:0] mem_idx;
    logic [DATA_WIDTH-1:0]  mem_rdata;

    // Address decode and selection of the request being committed.
    // With LATENCY 1 the commit edge is the accept edge, so it comes
    // straight from the bus; otherwise from the saved request.
    always_comb begin
        off     = bus.addr - BASE_ADDR;
        in_idx  = off[OFFW +: INDEX_WIDTH];
        in_flt  = (bus.addr < BASE_ADDR) || (off >= SPAN);
        accept  = bus.valid && ready_q;
        commit  = FROM_BUS ? accept : (state_q == WAIT && cnt_q == 4'd0);
        c_idx   = FROM_BUS ? in_idx    : idx_q;
        c_wen   = FROM_BUS ? bus.wen   : wen_q;
        c_flt   = FROM_BUS ? in_flt    : flt_q;
        c_wdata = FROM_BUS ? bus.wdata : wdata_q;
        c_wmask = FROM_BUS ? bus.wmask : wmask_q;
        mem_we  = commit && c_wen && !c_flt;
        mem_idx = commit ? c_idx : rd_idx_q;
    end

    membus_ram_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .INIT_FILE   (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (c_wmask),
        .idx   (mem_idx),
        .wdata (c_wdata),
        .rdata (mem_rdata)
    );

    // Request FSM, latency counter, saved request and response flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            rzero_q  <= 1'b1;
            rd_idx_q <= '0;
            idx_q    <= '0;
            wen_q    <= 1'b0;
            flt_q    <= 1'b0;
            wdata_q  <= '0;
            wmask_q  <= '0;
        end else begin
            rvalid_q <= commit;
            fault_q  <= commit && c_flt;
            if (commit) begin
                rzero_q  <= c_wen || c_flt;
                rd_idx_q <= c_idx;
            end
            if (accept) begin
                idx_q   <= in_idx;
                wen_q   <= bus.wen;
                flt_q   <= in_flt;
                wdata_q <= bus.wdata;
                wmask_q <= bus.wmask;
            end
            unique case (state_q)
                IDLE, RESP: begin
                    if (accept && FROM_BUS) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else if (accept) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_INIT;
                        ready_q <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.rvalid   = rvalid_q;
    assign bus.rdata    = rzero_q ? '0 : mem_rdata;
    assign access_fault = fault_q;

endmodule

// File: tb/tb_membus_ram_responder.sv
// Scoreboard bench for membus_ram_responder at latencies 1, 3 and 4.
// Stimulus pushes expected responses; monitors pop them on rvalid.
module tb_membus_ram_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] SPAN = 64'h8000;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst4 = 1'b1;
    logic f1, f3, f4;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    membus_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) b1 ();
    membus_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) b3 ();
    membus_if #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) b4 ();

    membus_ram_responder #(
        .INDEX_WIDTH(12), .BASE_ADDR(BASE), .LATENCY(1)
    ) dut1 (.clk(clk), .rst(rst_a), .bus(b1), .access_fault(f1));

    membus_ram_responder #(
        .INDEX_WIDTH(12), .BASE_ADDR(BASE), .LATENCY(3)
    ) dut3 (.clk(clk), .rst(rst_a), .bus(b3), .access_fault(f3));

    membus_ram_responder #(
        .INDEX_WIDTH(12), .BASE_ADDR(BASE), .LATENCY(4)
    ) dut4 (.clk(clk), .rst(rst4), .bus(b4), .access_fault(f4));

    typedef struct {
        logic [63:0] d;
        logic        f;
        int          c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic [63:0] mdl [int];
    int checks = 0;
    int errors = 0;
    int rv0 = 0, rv1 = 0, rv2 = 0;
    int p0 = 0, p1 = 0, p2 = 0;
    int stalls = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    function automatic int lat(int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic drive(int d, logic v, logic [63:0] a, logic w,
                         logic [63:0] wd, logic [7:0] m);
        case (d)
            0: begin
                b1.valid = v; b1.addr = a; b1.wen = w;
                b1.wdata = wd; b1.wmask = m;
            end
            1: begin
                b3.valid = v; b3.addr = a; b3.wen = w;
                b3.wdata = wd; b3.wmask = m;
            end
            default: begin
                b4.valid = v; b4.addr = a; b4.wen = w;
                b4.wdata = wd; b4.wmask = m;
            end
        endcase
    endtask

    function automatic logic rdy(int d);
        case (d)
            0:       return b1.ready;
            1:       return b3.ready;
            default: return b4.ready;
        endcase
    endfunction

    task automatic push(int d, exp_t e);
        case (d)
            0: begin q0.push_back(e); p0++; end
            1: begin q1.push_back(e); p1++; end
            default: begin q2.push_back(e); p2++; end
        endcase
    endtask

    // Present one request, wait for acceptance, queue the expected response.
    task automatic issue(int d, logic [63:0] a, logic w, logic [63:0] wd,
                         logic [7:0] m, bit hand = 1'b0,
                         logic [63:0] hv = '0, bit nopush = 1'b0);
        int n = 0;
        bit acc = 1'b0;
        logic [63:0] off;
        logic [63:0] word;
        bit flt;
        int key;
        exp_t e;
        drive(d, 1'b1, a, w, wd, m);
        while (!acc && n < 40) begin
            acc = rdy(d);
            @(posedge clk);
            #1;
            n++;
        end
        drive(d, 1'b0, a, w, wd, m);
        if (!acc) begin
            chk("accept_timeout", 64'd0, 64'd1);
            return;
        end
        stalls += n - 1;
        off = a - BASE;
        flt = (a < BASE) || (off >= SPAN);
        key = d * 4096 + int'(off[14:3]);
        e.f = flt;
        e.c = cyc + lat(d) - 1;
        e.d = '0;
        if (!flt && w && !nopush) begin
            word = mdl.exists(key) ? mdl[key] : '0;
            for (int k = 0; k < 8; k++) begin
                if (m[k]) word[k*8 +: 8] = wd[k*8 +: 8];
            end
            mdl[key] = word;
        end else if (!flt && !w) begin
            e.d = hand ? hv : (mdl.exists(key) ? mdl[key] : '0);
        end
        if (!nopush) push(d, e);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    endtask

    // Latency-1 response monitor.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (b1.rvalid) begin
            rv0++;
            if (q0.size() == 0) begin
                chk("extra_rvalid_l1", 64'(rv0), 64'(p0));
            end else begin
                e = q0.pop_front();
                chk("rdata_l1", b1.rdata, e.d);
                chk("fault_l1", 64'(f1), 64'(e.f));
                chk("latency_l1", 64'(cyc), 64'(e.c));
            end
        end
    end

    // Latency-3 response monitor.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (b3.rvalid) begin
            rv1++;
            if (q1.size() == 0) begin
                chk("extra_rvalid_l3", 64'(rv1), 64'(p1));
            end else begin
                e = q1.pop_front();
                chk("rdata_l3", b3.rdata, e.d);
                chk("fault_l3", 64'(f3), 64'(e.f));
                chk("latency_l3", 64'(cyc), 64'(e.c));
            end
        end
    end

    // Latency-4 response monitor.
    always @(negedge clk) begin : mon2
        exp_t e;
        if (b4.rvalid) begin
            rv2++;
            if (q2.size() == 0) begin
                chk("extra_rvalid_l4", 64'(rv2), 64'(p2));
            end else begin
                e = q2.pop_front();
                chk("rdata_l4", b4.rdata, e.d);
                chk("fault_l4", 64'(f4), 64'(e.f));
                chk("latency_l4", 64'(cyc), 64'(e.c));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r;
        int idx;
        logic [63:0] a;
        exp_t e;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, '0, 1'b0, '0, '0);
        #2;
        rst_a = 1'b0;
        rst4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ready", 64'(b1.ready), 64'd1);
        chk("rst_hold_rvalid", 64'(b1.rvalid), 64'd0);
        rst_a = 1'b1;
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(b1.ready), 64'd1);
        chk("rst_rvalid", 64'(b1.rvalid), 64'd0);
        chk("rst_rdata", b1.rdata, 64'd0);
        chk("rst_fault", 64'(f1), 64'd0);
        chk("rst_ready_l3", 64'(b3.ready), 64'd1);

        issue(0, BASE, 1'b1, 64'h5555_6666_7777_8888, 8'hFF);
        issue(0, BASE + 64'h8, 1'b1, 64'h1122_3344_5566_7788, 8'hFF);
        issue(0, BASE + 64'h8, 1'b1, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
        issue(0, BASE + 64'h8, 1'b0, '0, '0, 1'b1, 64'h1122_3344_BBBB_BBBB);
        issue(0, BASE + 64'h8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        issue(0, BASE + 64'hC, 1'b0, '0, '0, 1'b1, 64'h1122_3344_BBBB_BBBB);
        issue(0, BASE + SPAN, 1'b1, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
        issue(0, BASE + SPAN, 1'b0, '0, '0);
        issue(0, BASE - 64'h8, 1'b0, '0, '0);
        issue(0, BASE, 1'b0, '0, '0, 1'b1, 64'h5555_6666_7777_8888);
        issue(0, BASE + 64'h8, 1'b0, '0, '0, 1'b1, 64'h1122_3344_BBBB_BBBB);
        drain();

        issue(1, BASE + 64'h10, 1'b1, 64'h0F0E_0D0C_0B0A_0908, 8'hFF);
        drain();
        r = rv1;
        drive(1, 1'b1, BASE + 64'h10, 1'b0, '0, '0);
        chk("l3_ready_idle", 64'(b3.ready), 64'd1);
        @(posedge clk);
        #1;
        e.d = 64'h0F0E_0D0C_0B0A_0908;
        e.f = 1'b0;
        e.c = cyc + 2;
        push(1, e);
        chk("l3_wait1_ready", 64'(b3.ready), 64'd0);
        chk("l3_wait1_rvalid", 64'(b3.rvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("l3_wait2_ready", 64'(b3.ready), 64'd0);
        chk("l3_wait2_rvalid", 64'(b3.rvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("l3_resp_rvalid", 64'(b3.rvalid), 64'd1);
        chk("l3_resp_ready", 64'(b3.ready), 64'd1);
        drive(1, 1'b0, BASE + 64'h10, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        chk("l3_idle_rvalid", 64'(b3.rvalid), 64'd0);
        chk("l3_single_rvalid", 64'(rv1 - r), 64'd1);
        issue(1, BASE + 64'h18, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hF0);
        issue(1, BASE + 64'h10, 1'b0, '0, '0, 1'b1, 64'h0F0E_0D0C_0B0A_0908);
        issue(1, BASE + 64'h18, 1'b1, 64'h0000_0000_CCCC_DDDD, 8'h0F);
        issue(1, BASE + 64'h18, 1'b0, '0, '0, 1'b1, 64'h1234_5678_CCCC_DDDD);
        drain();

        issue(2, BASE + 64'h20, 1'b1, 64'hCAFE_BABE_DEAD_BEEF, 8'hFF);
        drain();
        issue(2, BASE + 64'h20, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF,
              1'b0, '0, 1'b1);
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        #2;
        chk("l4_rst_ready", 64'(b4.ready), 64'd1);
        chk("l4_rst_rvalid", 64'(b4.rvalid), 64'd0);
        rst4 = 1'b1;
        r = rv2;
        repeat (8) @(posedge clk);
        #1;
        chk("l4_rst_no_rvalid", 64'(rv2), 64'(r));
        issue(2, BASE + 64'h20, 1'b0, '0, '0, 1'b1, 64'hCAFE_BABE_DEAD_BEEF);
        drain();

        for (int i = 0; i < 16; i++) begin
            issue(0, BASE + 64'(i * 8), 1'b1, {$urandom, $urandom}, 8'hFF);
        end
        stalls = 0;
        for (int i = 0; i < 100; i++) begin
            idx = $urandom_range(0, 15);
            a = BASE + 64'(idx * 8) + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = a + SPAN;
            issue(0, a, 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  8'($urandom));
        end
        chk("b2b_stalls", 64'(stalls), 64'd0);
        drain();
        chk("rvalid_count_l1", 64'(rv0), 64'(p0));
        chk("rvalid_count_l3", 64'(rv1), 64'(p1));
        chk("rvalid_count_l4", 64'(rv2), 64'(p2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
